// File: rtl/trigger_pkg.sv
// Shared constants and helpers for the trigger comparator channels.
// Mode encoding matches the cfg_mod field of trigger_compare.
package trigger_pkg;

    localparam logic [1:0] TRG_GE = 2'd0;
    localparam logic [1:0] TRG_LT = 2'd1;
    localparam logic [1:0] TRG_EQ = 2'd2;
    localparam logic [1:0] TRG_NE = 2'd3;

    typedef enum logic [1:0] {
        MODE_GE = TRG_GE,
        MODE_LT = TRG_LT,
        MODE_EQ = TRG_EQ,
        MODE_NE = TRG_NE
    } trg_mode_e;

    function automatic logic trg_cond(
        input logic [1:0] mode,
        input logic       lt,
        input logic       eq
    );
        logic c;
        c = 1'b0;
        unique case (mode)
            TRG_GE: c = !lt;
            TRG_LT: c = lt;
            TRG_EQ: c = eq;
            TRG_NE: c = !eq;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/trigger_compare_channel.sv
// One comparator channel: stage-1 masked subtract/equal, stage-2 run
// counter with saturating length and level or single-pulse event.
module trigger_compare_channel
    import trigger_pkg::*;
#(
    parameter int SDW = 32,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic [1:0]     mode,
    input  logic           edg,
    input  logic [SDW-1:0] msk,
    input  logic [SDW-1:0] val,
    input  logic [CW-1:0]  len,
    input  logic           transfer,
    input  logic [SDW-1:0] tdata,
    input  logic           vld1,
    output logic           evt
);

    localparam logic [CW-1:0] ONE = CW'(1);

    logic [SDW-1:0] dat_m;
    logic [SDW:0]   dif;
    logic           lt_q;
    logic           eq_q;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [CW-1:0]  len_eff;
    logic           cond;
    logic           hit;
    logic           evt_nxt;

    assign dat_m = tdata & msk;
    assign dif   = {1'b0, dat_m} - {1'b0, val};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lt_q <= 1'b0;
            eq_q <= 1'b0;
        end else if (transfer) begin
            lt_q <= dif[SDW];
            eq_q <= (dif == '0);
        end
    end

    assign len_eff = (len == '0) ? ONE : len;
    assign cond    = trg_cond(mode, lt_q, eq_q);

    always_comb begin
        cnt_nxt = cnt;
        if (vld1) begin
            if (!cond)
                cnt_nxt = '0;
            else if (cnt >= len_eff)
                cnt_nxt = len_eff;
            else
                cnt_nxt = cnt + ONE;
        end
    end

    assign hit = (cnt_nxt == len_eff);

    // A pulse fires only when the run crosses into the target length.
    always_comb begin
        evt_nxt = hit;
        if (edg)
            evt_nxt = vld1 && cond && (cnt != len_eff) && hit;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            evt <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            evt <= evt_nxt;
        end
    end

endmodule

// File: rtl/trigger_compare.sv
// Multi-channel stream comparator feeding per-channel and combined
// events to the trigger sequencer.
module trigger_compare
    import trigger_pkg::*;
#(
    parameter int SDW = 32,
    parameter int CNT = 4,
    parameter int CW  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctl_clr,
    input  logic [2*CNT-1:0]   cfg_mod,
    input  logic [CNT-1:0]     cfg_edg,
    input  logic [SDW*CNT-1:0] cfg_msk,
    input  logic [SDW*CNT-1:0] cfg_val,
    input  logic [CW*CNT-1:0]  cfg_len,
    output logic [CNT-1:0]     sts_evt,
    output logic               sts_any,
    input  logic               sti_transfer,
    input  logic [SDW-1:0]     sti_tdata
);

    logic vld1;

    always_ff @(posedge clk) begin
        if (rst || ctl_clr)
            vld1 <= 1'b0;
        else
            vld1 <= sti_transfer;
    end

    for (genvar c = 0; c < CNT; c++) begin : g_ch
        trigger_compare_channel #(
            .SDW (SDW),
            .CW  (CW)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .clr      (ctl_clr),
            .mode     (cfg_mod[c*2 +: 2]),
            .edg      (cfg_edg[c]),
            .msk      (cfg_msk[c*SDW +: SDW]),
            .val      (cfg_val[c*SDW +: SDW]),
            .len      (cfg_len[c*CW +: CW]),
            .transfer (sti_transfer),
            .tdata    (sti_tdata),
            .vld1     (vld1),
            .evt      (sts_evt[c])
        );
    end

    assign sts_any = |sts_evt;

endmodule

// File: tb/tb_trigger_compare.sv
// Self-checking bench for trigger_compare: behavioural run-length model
// plus hand-computed expectations at key points.
module tb_trigger_compare;

    localparam int SDW = 32;
    localparam int CNT = 4;
    localparam int CW  = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               ctl_clr = 1'b0;
    logic [2*CNT-1:0]   cfg_mod = '0;
    logic [CNT-1:0]     cfg_edg = '0;
    logic [SDW*CNT-1:0] cfg_msk = '0;
    logic [SDW*CNT-1:0] cfg_val = '0;
    logic [CW*CNT-1:0]  cfg_len = '0;
    logic [CNT-1:0]     sts_evt;
    logic               sts_any;
    logic               sti_transfer = 1'b0;
    logic [SDW-1:0]     sti_tdata = '0;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int pulses2 = 0;

    trigger_compare #(.SDW(SDW), .CNT(CNT), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ctl_clr      (ctl_clr),
        .cfg_mod      (cfg_mod),
        .cfg_edg      (cfg_edg),
        .cfg_msk      (cfg_msk),
        .cfg_val      (cfg_val),
        .cfg_len      (cfg_len),
        .sts_evt      (sts_evt),
        .sts_any      (sts_any),
        .sti_transfer (sti_transfer),
        .sti_tdata    (sti_tdata)
    );

    always #5 clk = ~clk;

    // Model: a captured sample is judged one edge later against the run rule.
    bit             p_vld = 1'b0;
    bit             p_ge[CNT];
    bit             p_eq[CNT];
    int             run[CNT];
    logic [CNT-1:0] exp_evt = '0;

    always @(posedge clk) begin
        if (rst || ctl_clr) begin
            p_vld = 1'b0;
            for (int c = 0; c < CNT; c++) run[c] = 0;
            exp_evt = '0;
        end else begin
            for (int c = 0; c < CNT; c++) begin
                int  l;
                int  prev;
                bit  ok;
                l = int'(cfg_len[c*CW +: CW]);
                if (l == 0) l = 1;
                if (p_vld) begin
                    case (int'(cfg_mod[c*2 +: 2]))
                        0: ok = p_ge[c];
                        1: ok = !p_ge[c];
                        2: ok = p_eq[c];
                        default: ok = !p_eq[c];
                    endcase
                    prev = run[c];
                    run[c] = ok ? ((run[c] + 1 > l) ? l : run[c] + 1) : 0;
                    if (cfg_edg[c])
                        exp_evt[c] = ok && prev != l && run[c] == l;
                    else
                        exp_evt[c] = run[c] == l;
                end else begin
                    exp_evt[c] = cfg_edg[c] ? 1'b0 : (run[c] == l);
                end
            end
            p_vld = sti_transfer;
            if (sti_transfer) begin
                for (int c = 0; c < CNT; c++) begin
                    logic [SDW-1:0] m;
                    logic [SDW-1:0] v;
                    m = sti_tdata & cfg_msk[c*SDW +: SDW];
                    v = cfg_val[c*SDW +: SDW];
                    p_ge[c] = m >= v;
                    p_eq[c] = m == v;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (sts_evt !== exp_evt) begin
                fails++;
                $display("FAIL model_evt t=%0t got=%b want=%b",
                         $time, sts_evt, exp_evt);
            end
            tests++;
            if (sts_any !== (|exp_evt)) begin
                fails++;
                $display("FAIL model_any t=%0t got=%b want=%b",
                         $time, sts_any, |exp_evt);
            end
            if (sts_evt[2]) pulses2++;
        end
    end

    task automatic step(input logic x, input logic [SDW-1:0] d);
        sti_transfer = x;
        sti_tdata    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [CNT-1:0] want);
        tests++;
        if (sts_evt !== want) begin
            fails++;
            $display("FAIL %s got=%b want=%b", name, sts_evt, want);
        end
    endtask

    task automatic cfg_ch(input int c, input logic [1:0] m, input logic e,
                          input logic [SDW-1:0] k, input logic [SDW-1:0] v,
                          input logic [CW-1:0] l);
        cfg_mod[c*2 +: 2]     = m;
        cfg_edg[c]            = e;
        cfg_msk[c*SDW +: SDW] = k;
        cfg_val[c*SDW +: SDW] = v;
        cfg_len[c*CW +: CW]   = l;
    endtask

    task automatic quiet(input int c);
        cfg_ch(c, 2'd2, 1'b0, 32'h0, 32'h1, 16'd1);
    endtask

    task automatic do_clr();
        ctl_clr = 1'b1;
        step(1'b0, '0);
        ctl_clr = 1'b0;
    endtask

    logic [SDW-1:0] tbl [16] = '{
        32'h0000_0081, 32'h0000_0010, 32'h0000_0F05, 32'hFFFF_FF7F,
        32'h0000_0095, 32'h0000_1000, 32'h0000_0005, 32'h0000_0005,
        32'h0000_0005, 32'h1234_5600, 32'h0000_00F5, 32'h0000_0080,
        32'h0000_0FFF, 32'h0000_0025, 32'h8000_0005, 32'h0000_0000
    };

    initial begin
        rst = 1'b1;
        step(1'b0, '0);
        step(1'b0, '0);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_zero", 4'b0000);

        cfg_ch(0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h100, 16'd1);
        cfg_ch(1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h100, 16'd1);
        cfg_ch(2, 2'd2, 1'b0, 32'h0000_00F0, 32'h30, 16'd1);
        cfg_ch(3, 2'd3, 1'b0, 32'h0000_00F0, 32'h30, 16'd1);
        step(1'b1, 32'h100);
        check("lat_one", 4'b0000);
        step(1'b0, '0);
        check("ge_eqval", 4'b1001);
        step(1'b1, 32'hFF);
        step(1'b0, '0);
        check("lt_ff", 4'b1010);
        step(1'b1, 32'hFFFF_FFFF);
        step(1'b0, '0);
        check("ge_max", 4'b1001);
        step(1'b1, 32'hABCD_EF37);
        step(1'b0, '0);
        check("eq_masked", 4'b0101);
        step(1'b1, 32'hABCD_EF3C);
        step(1'b0, '0);
        check("eq_nibble", 4'b0101);
        step(1'b1, 32'h40);
        step(1'b0, '0);
        check("ne_40", 4'b1010);

        do_clr();
        cfg_ch(0, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'h55, 16'd3);
        cfg_ch(1, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'h55, 16'd0);
        quiet(2);
        quiet(3);
        step(1'b1, 32'h55);
        step(1'b1, 32'h55);
        step(1'b0, '0);
        step(1'b1, 32'h55);
        step(1'b1, 32'h99);
        check("run3_gap", 4'b0011);
        step(1'b1, 32'h55);
        check("run_reset", 4'b0000);
        step(1'b1, 32'h55);
        check("run_one", 4'b0010);
        step(1'b1, 32'h55);
        check("run_two", 4'b0010);
        step(1'b0, '0);
        check("run_three", 4'b0011);
        step(1'b0, '0);
        check("run_hold", 4'b0011);

        rst = 1'b1;
        step(1'b0, '0);
        rst = 1'b0;
        check("rst_midrun", 4'b0000);
        step(1'b1, 32'h55);
        step(1'b0, '0);
        check("rst_cnt0", 4'b0010);
        ctl_clr = 1'b1;
        step(1'b1, 32'h55);
        ctl_clr = 1'b0;
        check("clr_drop", 4'b0000);
        step(1'b0, '0);
        check("clr_nomatch", 4'b0000);

        quiet(0);
        quiet(1);
        cfg_ch(2, 2'd2, 1'b1, 32'hFFFF_FFFF, 32'h55, 16'd2);
        do_clr();
        pulses2 = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 32'h55);
        step(1'b0, '0);
        step(1'b0, '0);
        step(1'b1, 32'h11);
        step(1'b1, 32'h55);
        step(1'b1, 32'h55);
        step(1'b0, '0);
        step(1'b0, '0);
        step(1'b0, '0);
        tests++;
        if (pulses2 != 2) begin
            fails++;
            $display("FAIL edge_pulses got=%0d want=2", pulses2);
        end

        cfg_ch(0, 2'd0, 1'b0, 32'h0000_00FF, 32'h80, 16'd2);
        cfg_ch(1, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'h1000, 16'd1);
        cfg_ch(2, 2'd2, 1'b1, 32'h0000_000F, 32'h5, 16'd3);
        cfg_ch(3, 2'd3, 1'b0, 32'h0000_00F0, 32'h0, 16'd2);
        do_clr();
        for (int i = 0; i < 160; i++) begin
            if (i >= 100 && (i % 7) == 3)
                step(1'b0, tbl[i % 16]);
            else
                step(1'b1, tbl[(i * 5 + i / 3) % 16]);
        end
        step(1'b0, '0);
        step(1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
